reorder_buffer: RTL and testbench

//  In-order retirement buffer for the dual-issue renamed core. Allocates up to 2 entries/cycle at rename,

---
 rtl/Falco_pkg.sv | 36 +++
 rtl/rob_retire_select.sv | 20 ++
 rtl/reorder_buffer.sv | 180 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/Falco_pkg.sv
// Shared defaults and types for the Falco rename/retire slice.
// Widths here follow the default ROB depth and PRF count.
package Falco_pkg;

    localparam int ROB_DEPTH_DEFAULT = 32;
    localparam int PRF_NUM_DEFAULT   = 64;
    localparam int ARF_W             = 5;
    localparam int PRF_W_DEFAULT     = $clog2(PRF_NUM_DEFAULT);
    localparam int ROB_IDX_W_DEFAULT = $clog2(ROB_DEPTH_DEFAULT);

    typedef logic [ROB_IDX_W_DEFAULT-1:0] rob_idx_t;
    typedef logic [PRF_W_DEFAULT-1:0]     prf_specifier_t;
    typedef logic [ARF_W-1:0]             arf_specifier_t;

    // Per-entry bookkeeping that decides retirement; width-independent.
    typedef struct packed {
        logic valid;
        logic done;
        logic mispredict;
    } rob_status_t;

    typedef struct packed {
        rob_status_t    status;
        logic           wen;
        arf_specifier_t arf;
        prf_specifier_t prf;
        prf_specifier_t old_prf;
    } rob_entry_t;

    typedef struct packed {
        logic           update;
        arf_specifier_t arf;
        prf_specifier_t prf;
    } committed_update_t;

endpackage

// File: rtl/rob_retire_select.sv
// Picks how many of the two oldest entries retire this cycle and whether the
// oldest one is a mispredicted branch that must flush the machine.
module rob_retire_select
    import Falco_pkg::*;
(
    input  rob_status_t head_i,
    input  rob_status_t next_i,
    output logic        r0_o,
    output logic        r1_o,
    output logic        flush_req_o
);

    // A mispredicted head retires alone; everything younger is wrong-path.
    always_comb begin
        r0_o        = head_i.valid & head_i.done;
        r1_o        = r0_o & ~head_i.mispredict & next_i.valid & next_i.done;
        flush_req_o = r0_o & head_i.mispredict;
    end

endmodule

// File: rtl/reorder_buffer.sv
// Dual-issue reorder buffer: in-order allocate, out-of-order complete, in-order
// retire with registered committed-map/free-list outputs and mispredict flush.
module reorder_buffer
    import Falco_pkg::*;
#(
    parameter int  ROB_DEPTH = ROB_DEPTH_DEFAULT,
    parameter int  PRF_NUM   = PRF_NUM_DEFAULT,
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH),
    localparam int PRF_W     = $clog2(PRF_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid_0,
    input  logic                 alloc_valid_1,
    input  logic                 alloc_wen_0,
    input  logic                 alloc_wen_1,
    input  logic [ARF_W-1:0]     alloc_arf_0,
    input  logic [ARF_W-1:0]     alloc_arf_1,
    input  logic [PRF_W-1:0]     alloc_prf_0,
    input  logic [PRF_W-1:0]     alloc_prf_1,
    input  logic [PRF_W-1:0]     alloc_old_prf_0,
    input  logic [PRF_W-1:0]     alloc_old_prf_1,
    output logic                 alloc_ready,
    output logic [ROB_IDX_W-1:0] alloc_idx_0,
    output logic [ROB_IDX_W-1:0] alloc_idx_1,
    input  logic                 cmpl_valid_0,
    input  logic                 cmpl_valid_1,
    input  logic [ROB_IDX_W-1:0] cmpl_idx_0,
    input  logic [ROB_IDX_W-1:0] cmpl_idx_1,
    input  logic                 cmpl_mispredict_0,
    input  logic                 cmpl_mispredict_1,
    output logic                 map_update_0,
    output logic                 map_update_1,
    output logic [ARF_W-1:0]     map_arf_0,
    output logic [ARF_W-1:0]     map_arf_1,
    output logic [PRF_W-1:0]     map_prf_0,
    output logic [PRF_W-1:0]     map_prf_1,
    output logic                 free_valid_0,
    output logic                 free_valid_1,
    output logic [PRF_W-1:0]     free_prf_0,
    output logic [PRF_W-1:0]     free_prf_1,
    output logic                 flush
);

    localparam logic [ROB_IDX_W:0] DEPTH_C = (ROB_IDX_W+1)'(ROB_DEPTH);

    typedef struct packed {
        rob_status_t      status;
        logic             wen;
        logic [ARF_W-1:0] arf;
        logic [PRF_W-1:0] prf;
        logic [PRF_W-1:0] old_prf;
    } entry_t;

    typedef struct packed {
        logic             update;
        logic [ARF_W-1:0] arf;
        logic [PRF_W-1:0] prf;
        logic             free_valid;
        logic [PRF_W-1:0] free_prf;
    } commit_t;

    entry_t                entries_q [ROB_DEPTH];
    entry_t                entries_d [ROB_DEPTH];
    logic [ROB_IDX_W-1:0]  head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
    logic [ROB_IDX_W:0]    count_q, count_d, n_alloc, n_retire;
    entry_t                head_entry, next_entry;
    logic                  accept_0, accept_1, r0, r1, flush_req;
    commit_t               commit_0_q, commit_0_d, commit_1_q, commit_1_d;
    logic                  flush_q;

    assign head_p1     = head_q + ROB_IDX_W'(1);
    assign tail_p1     = tail_q + ROB_IDX_W'(1);
    assign head_entry  = entries_q[head_q];
    assign next_entry  = entries_q[head_p1];
    // Full and empty share pointer values, so occupancy comes from count alone.
    assign alloc_ready = ((DEPTH_C - count_q) >= (ROB_IDX_W+1)'(2)) && !flush_q;
    assign alloc_idx_0 = tail_q;
    assign alloc_idx_1 = tail_p1;
    assign accept_0    = alloc_ready & alloc_valid_0;
    assign accept_1    = accept_0 & alloc_valid_1;
    assign n_alloc     = (ROB_IDX_W+1)'(accept_0) + (ROB_IDX_W+1)'(accept_1);
    assign n_retire    = (ROB_IDX_W+1)'(r0) + (ROB_IDX_W+1)'(r1);

    rob_retire_select u_retire_select (
        .head_i      (head_entry.status),
        .next_i      (next_entry.status),
        .r0_o        (r0),
        .r1_o        (r1),
        .flush_req_o (flush_req)
    );

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q + n_retire[ROB_IDX_W-1:0];
        tail_d    = tail_q + n_alloc[ROB_IDX_W-1:0];
        count_d   = count_q + n_alloc - n_retire;

        if (cmpl_valid_0 && entries_q[cmpl_idx_0].status.valid) begin
            entries_d[cmpl_idx_0].status.done       = 1'b1;
            entries_d[cmpl_idx_0].status.mispredict = entries_d[cmpl_idx_0].status.mispredict | cmpl_mispredict_0;
        end
        if (cmpl_valid_1 && entries_q[cmpl_idx_1].status.valid) begin
            entries_d[cmpl_idx_1].status.done       = 1'b1;
            entries_d[cmpl_idx_1].status.mispredict = entries_d[cmpl_idx_1].status.mispredict | cmpl_mispredict_1;
        end

        if (r0) entries_d[head_q].status  = '0;
        if (r1) entries_d[head_p1].status = '0;

        if (accept_0) begin
            entries_d[tail_q].status  = '{valid: 1'b1, done: 1'b0, mispredict: 1'b0};
            entries_d[tail_q].wen     = alloc_wen_0;
            entries_d[tail_q].arf     = alloc_arf_0;
            entries_d[tail_q].prf     = alloc_prf_0;
            entries_d[tail_q].old_prf = alloc_old_prf_0;
        end
        if (accept_1) begin
            entries_d[tail_p1].status  = '{valid: 1'b1, done: 1'b0, mispredict: 1'b0};
            entries_d[tail_p1].wen     = alloc_wen_1;
            entries_d[tail_p1].arf     = alloc_arf_1;
            entries_d[tail_p1].prf     = alloc_prf_1;
            entries_d[tail_p1].old_prf = alloc_old_prf_1;
        end

        // Wrong-path work is discarded wholesale, including this cycle's allocs/completions.
        if (flush_req) begin
            for (int i = 0; i < ROB_DEPTH; i++) entries_d[i].status = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        commit_0_d = '0;
        commit_1_d = '0;
        if (r0 && head_entry.wen) begin
            commit_0_d = '{update: 1'b1, arf: head_entry.arf, prf: head_entry.prf,
                           free_valid: 1'b1, free_prf: head_entry.old_prf};
        end
        if (r1 && next_entry.wen) begin
            commit_1_d = '{update: 1'b1, arf: next_entry.arf, prf: next_entry.prf,
                           free_valid: 1'b1, free_prf: next_entry.old_prf};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            commit_0_q <= '0;
            commit_1_q <= '0;
            flush_q    <= 1'b0;
        end else begin
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            commit_0_q <= commit_0_d;
            commit_1_q <= commit_1_d;
            flush_q    <= flush_req;
        end
    end

    assign map_update_0 = commit_0_q.update;
    assign map_arf_0    = commit_0_q.arf;
    assign map_prf_0    = commit_0_q.prf;
    assign free_valid_0 = commit_0_q.free_valid;
    assign free_prf_0   = commit_0_q.free_prf;
    assign map_update_1 = commit_1_q.update;
    assign map_arf_1    = commit_1_q.arf;
    assign map_prf_1    = commit_1_q.prf;
    assign free_valid_1 = commit_1_q.free_valid;
    assign free_prf_1   = commit_1_q.free_prf;
    assign flush        = flush_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, hand-written
// fill/wrap and async-reset sequences, then random traffic against a queue model.
module tb_reorder_buffer;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_valid_0, alloc_valid_1, alloc_wen_0, alloc_wen_1;
    logic [4:0] alloc_arf_0, alloc_arf_1;
    logic [5:0] alloc_prf_0, alloc_prf_1, alloc_old_prf_0, alloc_old_prf_1;
    logic       alloc_ready;
    logic [4:0] alloc_idx_0, alloc_idx_1;
    logic       cmpl_valid_0, cmpl_valid_1, cmpl_mispredict_0, cmpl_mispredict_1;
    logic [4:0] cmpl_idx_0, cmpl_idx_1;
    logic       map_update_0, map_update_1, free_valid_0, free_valid_1, flush;
    logic [4:0] map_arf_0, map_arf_1;
    logic [5:0] map_prf_0, map_prf_1, free_prf_0, free_prf_1;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst),
        .alloc_valid_0(alloc_valid_0), .alloc_valid_1(alloc_valid_1),
        .alloc_wen_0(alloc_wen_0), .alloc_wen_1(alloc_wen_1),
        .alloc_arf_0(alloc_arf_0), .alloc_arf_1(alloc_arf_1),
        .alloc_prf_0(alloc_prf_0), .alloc_prf_1(alloc_prf_1),
        .alloc_old_prf_0(alloc_old_prf_0), .alloc_old_prf_1(alloc_old_prf_1),
        .alloc_ready(alloc_ready), .alloc_idx_0(alloc_idx_0), .alloc_idx_1(alloc_idx_1),
        .cmpl_valid_0(cmpl_valid_0), .cmpl_valid_1(cmpl_valid_1),
        .cmpl_idx_0(cmpl_idx_0), .cmpl_idx_1(cmpl_idx_1),
        .cmpl_mispredict_0(cmpl_mispredict_0), .cmpl_mispredict_1(cmpl_mispredict_1),
        .map_update_0(map_update_0), .map_update_1(map_update_1),
        .map_arf_0(map_arf_0), .map_arf_1(map_arf_1),
        .map_prf_0(map_prf_0), .map_prf_1(map_prf_1),
        .free_valid_0(free_valid_0), .free_valid_1(free_valid_1),
        .free_prf_0(free_prf_0), .free_prf_1(free_prf_1),
        .flush(flush)
    );

    typedef struct {
        logic       av0, av1, wen0, wen1;
        logic [4:0] arf0, arf1;
        logic [5:0] prf0, prf1, old0, old1;
        logic       cv0, cv1, cm0, cm1;
        logic [4:0] ci0, ci1;
    } stim_t;

    typedef struct {
        logic       ready, flush, mu0, mu1;
        logic [4:0] idx0, arf0, arf1;
        logic [5:0] prf0, prf1, fprf0, fprf1;
    } expect_t;

    typedef struct {
        stim_t   s;
        expect_t e;
    } vector_t;

    typedef struct {
        logic       done, misp, wen;
        logic [4:0] arf;
        logic [5:0] prf, old;
        int         idx;
    } mEntry_t;

    int      total = 0;
    int      bad   = 0;
    vector_t vecs[17];
    mEntry_t modelQ[$];
    int      modelHead;
    logic    modelFlush;

    function automatic stim_t sIdle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t sAlloc(int n, logic w0, logic [4:0] a0, logic [5:0] p0, logic [5:0] o0,
                                     logic w1, logic [4:0] a1, logic [5:0] p1, logic [5:0] o1);
        stim_t s;
        s = sIdle();
        s.av0 = (n >= 1); s.wen0 = w0; s.arf0 = a0; s.prf0 = p0; s.old0 = o0;
        s.av1 = (n >= 2); s.wen1 = w1; s.arf1 = a1; s.prf1 = p1; s.old1 = o1;
        return s;
    endfunction

    function automatic stim_t sCmpl(logic v0, logic [4:0] i0, logic m0, logic v1, logic [4:0] i1, logic m1);
        stim_t s;
        s = sIdle();
        s.cv0 = v0; s.ci0 = i0; s.cm0 = m0;
        s.cv1 = v1; s.ci1 = i1; s.cm1 = m1;
        return s;
    endfunction

    function automatic expect_t eQuiet(logic ready, logic [4:0] idx0, logic fl);
        expect_t e;
        e = '{default: '0};
        e.ready = ready; e.idx0 = idx0; e.flush = fl;
        return e;
    endfunction

    function automatic expect_t eRetire(logic [4:0] idx0,
                                        logic m0, logic [4:0] a0, logic [5:0] p0, logic [5:0] f0,
                                        logic m1, logic [4:0] a1, logic [5:0] p1, logic [5:0] f1);
        expect_t e;
        e = eQuiet(1'b1, idx0, 1'b0);
        e.mu0 = m0; e.arf0 = a0; e.prf0 = p0; e.fprf0 = f0;
        e.mu1 = m1; e.arf1 = a1; e.prf1 = p1; e.fprf1 = f1;
        return e;
    endfunction

    task automatic applyStimulus(input stim_t s);
        alloc_valid_0 = s.av0; alloc_valid_1 = s.av1;
        alloc_wen_0 = s.wen0; alloc_wen_1 = s.wen1;
        alloc_arf_0 = s.arf0; alloc_arf_1 = s.arf1;
        alloc_prf_0 = s.prf0; alloc_prf_1 = s.prf1;
        alloc_old_prf_0 = s.old0; alloc_old_prf_1 = s.old1;
        cmpl_valid_0 = s.cv0; cmpl_valid_1 = s.cv1;
        cmpl_idx_0 = s.ci0; cmpl_idx_1 = s.ci1;
        cmpl_mispredict_0 = s.cm0; cmpl_mispredict_1 = s.cm1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkExpect(input string tag, input expect_t e);
        logic [4:0] idx1;
        idx1 = e.idx0 + 5'd1;
        checkOutput({tag, " alloc_ready"}, 32'(alloc_ready), 32'(e.ready));
        checkOutput({tag, " alloc_idx_0"}, 32'(alloc_idx_0), 32'(e.idx0));
        checkOutput({tag, " alloc_idx_1"}, 32'(alloc_idx_1), 32'(idx1));
        checkOutput({tag, " flush"}, 32'(flush), 32'(e.flush));
        checkOutput({tag, " map_update_0"}, 32'(map_update_0), 32'(e.mu0));
        checkOutput({tag, " map_update_1"}, 32'(map_update_1), 32'(e.mu1));
        checkOutput({tag, " free_valid_0"}, 32'(free_valid_0), 32'(e.mu0));
        checkOutput({tag, " free_valid_1"}, 32'(free_valid_1), 32'(e.mu1));
        if (e.mu0) begin
            checkOutput({tag, " map_arf_0"}, 32'(map_arf_0), 32'(e.arf0));
            checkOutput({tag, " map_prf_0"}, 32'(map_prf_0), 32'(e.prf0));
            checkOutput({tag, " free_prf_0"}, 32'(free_prf_0), 32'(e.fprf0));
        end
        if (e.mu1) begin
            checkOutput({tag, " map_arf_1"}, 32'(map_arf_1), 32'(e.arf1));
            checkOutput({tag, " map_prf_1"}, 32'(map_prf_1), 32'(e.prf1));
            checkOutput({tag, " free_prf_1"}, 32'(free_prf_1), 32'(e.fprf1));
        end
    endtask

    task automatic doReset();
        applyStimulus(sIdle());
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // Program-order queue model: retire from the front, allocate at the back,
    // slot numbers derived from the oldest slot plus occupancy.
    task automatic modelStep(input stim_t s, output expect_t e);
        logic rdy, r0, r1;
        rdy = ((DEPTH - modelQ.size()) >= 2) && !modelFlush;
        r0  = (modelQ.size() > 0) && modelQ[0].done;
        r1  = r0 && !modelQ[0].misp && (modelQ.size() > 1) && modelQ[1].done;
        e   = '{default: '0};
        if (r0) begin
            e.mu0 = modelQ[0].wen; e.arf0 = modelQ[0].arf; e.prf0 = modelQ[0].prf; e.fprf0 = modelQ[0].old;
        end
        if (r1) begin
            e.mu1 = modelQ[1].wen; e.arf1 = modelQ[1].arf; e.prf1 = modelQ[1].prf; e.fprf1 = modelQ[1].old;
        end
        if (r0 && modelQ[0].misp) begin
            modelQ.delete();
            modelHead  = 0;
            modelFlush = 1'b1;
        end else begin
            modelFlush = 1'b0;
            foreach (modelQ[k]) begin
                if (s.cv0 && modelQ[k].idx == int'(s.ci0)) begin
                    modelQ[k].done = 1'b1; modelQ[k].misp = modelQ[k].misp | s.cm0;
                end
                if (s.cv1 && modelQ[k].idx == int'(s.ci1)) begin
                    modelQ[k].done = 1'b1; modelQ[k].misp = modelQ[k].misp | s.cm1;
                end
            end
            if (r0) begin void'(modelQ.pop_front()); modelHead = (modelHead + 1) % DEPTH; end
            if (r1) begin void'(modelQ.pop_front()); modelHead = (modelHead + 1) % DEPTH; end
            if (rdy && s.av0) modelQ.push_back('{1'b0, 1'b0, s.wen0, s.arf0, s.prf0, s.old0, (modelHead + modelQ.size()) % DEPTH});
            if (rdy && s.av0 && s.av1) modelQ.push_back('{1'b0, 1'b0, s.wen1, s.arf1, s.prf1, s.old1, (modelHead + modelQ.size()) % DEPTH});
        end
        e.ready = ((DEPTH - modelQ.size()) >= 2) && !modelFlush;
        e.idx0  = 5'((modelHead + modelQ.size()) % DEPTH);
        e.flush = modelFlush;
    endtask

    function automatic stim_t randomStim(int cyc);
        stim_t s;
        int    busy;
        s    = sIdle();
        busy = ((cyc / 150) % 2 == 0) ? 1 : 3;
        s.av0  = ($urandom_range(0, 3) < 4 - busy) || (busy == 1);
        s.av1  = s.av0 && ($urandom_range(0, 1) == 1);
        s.wen0 = ($urandom_range(0, 3) != 0); s.wen1 = ($urandom_range(0, 3) != 0);
        s.arf0 = 5'($urandom); s.arf1 = 5'($urandom);
        s.prf0 = 6'($urandom); s.prf1 = 6'($urandom);
        s.old0 = 6'($urandom); s.old1 = 6'($urandom);
        s.cv0  = ($urandom_range(0, 3) < busy);
        s.cv1  = ($urandom_range(0, 3) < busy);
        s.ci0  = 5'($urandom); s.ci1 = 5'($urandom);
        if (modelQ.size() > 0 && $urandom_range(0, 7) != 0) s.ci0 = 5'(modelQ[$urandom_range(0, modelQ.size() - 1)].idx);
        if (modelQ.size() > 0 && $urandom_range(0, 7) != 0) s.ci1 = 5'(modelQ[$urandom_range(0, modelQ.size() - 1)].idx);
        s.cm0 = ($urandom_range(0, 39) == 0);
        s.cm1 = ($urandom_range(0, 39) == 0);
        return s;
    endfunction

    initial begin
        stim_t   s;
        expect_t e;

        // Each row: inputs for one cycle, outputs expected just after that edge.
        vecs[0]  = '{sAlloc(2, 1, 3, 40, 3, 1, 3, 41, 40), eQuiet(1, 2, 0)};
        vecs[1]  = '{sCmpl(1, 0, 0, 1, 1, 0), eQuiet(1, 2, 0)};
        vecs[2]  = '{sIdle(), eRetire(2, 1, 3, 40, 3, 1, 3, 41, 40)};
        vecs[3]  = '{sAlloc(2, 1, 5, 42, 5, 1, 6, 43, 6), eQuiet(1, 4, 0)};
        vecs[4]  = '{sCmpl(0, 0, 0, 1, 3, 0), eQuiet(1, 4, 0)};
        vecs[5]  = '{sIdle(), eQuiet(1, 4, 0)};
        vecs[6]  = '{sCmpl(1, 2, 0, 0, 0, 0), eQuiet(1, 4, 0)};
        vecs[7]  = '{sIdle(), eRetire(4, 1, 5, 42, 5, 1, 6, 43, 6)};
        vecs[8]  = '{sAlloc(2, 0, 0, 0, 0, 1, 7, 44, 7), eQuiet(1, 6, 0)};
        vecs[9]  = '{sCmpl(1, 4, 0, 1, 5, 0), eQuiet(1, 6, 0)};
        vecs[10] = '{sIdle(), eRetire(6, 0, 0, 0, 0, 1, 7, 44, 7)};
        vecs[11] = '{sAlloc(2, 0, 0, 0, 0, 1, 9, 45, 9), eQuiet(1, 8, 0)};
        vecs[12] = '{sCmpl(1, 6, 1, 1, 7, 0), eQuiet(1, 8, 0)};
        vecs[13] = '{sIdle(), eQuiet(0, 0, 1)};
        vecs[14] = '{sAlloc(2, 1, 1, 50, 1, 1, 2, 51, 2), eQuiet(1, 0, 0)};
        vecs[15] = '{sAlloc(1, 1, 1, 50, 1, 0, 0, 0, 0), eQuiet(1, 1, 0)};
        vecs[16] = '{sCmpl(1, 0, 0, 0, 0, 0), eQuiet(1, 1, 0)};

        doReset();
        checkExpect("reset", eQuiet(1, 0, 0));
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].s);
            tick();
            checkExpect($sformatf("vec%0d", i), vecs[i].e);
        end

        // Asynchronous reset while two done entries are about to retire.
        doReset();
        applyStimulus(sAlloc(2, 1, 1, 10, 1, 1, 2, 11, 2)); tick();
        applyStimulus(sAlloc(2, 1, 3, 12, 3, 1, 4, 13, 4)); tick();
        applyStimulus(sAlloc(1, 1, 5, 14, 5, 0, 0, 0, 0));  tick();
        checkExpect("pre-reset", eQuiet(1, 5, 0));
        applyStimulus(sCmpl(1, 0, 0, 1, 1, 0)); tick();
        applyStimulus(sIdle());
        rst = 1'b1;
        #1;
        checkExpect("async reset", eQuiet(1, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkExpect("after reset", eQuiet(1, 0, 0));

        // Fill to one short of full, then retire and allocate across the wrap.
        doReset();
        for (int i = 0; i < 31; i++) begin
            applyStimulus(sAlloc(1, 1, 5'(i), 6'(i), 6'(63 - i), 0, 0, 0, 0));
            tick();
            checkOutput($sformatf("fill%0d alloc_ready", i), 32'(alloc_ready), 32'((DEPTH - (i + 1)) >= 2));
        end
        applyStimulus(sAlloc(1, 1, 9, 9, 9, 0, 0, 0, 0)); tick();
        checkExpect("full ignore", eQuiet(0, 31, 0));
        applyStimulus(sCmpl(1, 0, 0, 1, 1, 0)); tick();
        checkExpect("full cmpl", eQuiet(0, 31, 0));
        applyStimulus(sIdle()); tick();
        checkExpect("full retire", eRetire(31, 1, 0, 0, 63, 1, 1, 1, 62));
        applyStimulus(sCmpl(1, 2, 0, 1, 3, 0)); tick();
        checkExpect("wrap cmpl", eQuiet(1, 31, 0));
        applyStimulus(sAlloc(2, 1, 20, 33, 20, 1, 21, 34, 21)); tick();
        checkExpect("wrap alloc+retire", eRetire(1, 1, 2, 2, 61, 1, 3, 3, 60));
        applyStimulus(sAlloc(1, 1, 22, 35, 22, 0, 0, 0, 0)); tick();
        checkExpect("count30", eQuiet(1, 2, 0));
        applyStimulus(sAlloc(1, 1, 23, 36, 23, 0, 0, 0, 0)); tick();
        checkExpect("count31", eQuiet(0, 3, 0));

        // Random traffic against the queue model.
        doReset();
        modelQ.delete();
        modelHead  = 0;
        modelFlush = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s = randomStim(cyc);
            applyStimulus(s);
            modelStep(s, e);
            tick();
            checkExpect($sformatf("rand%0d", cyc), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
